hb_coeff_loader: RTL and testbench



---
 rtl/hb_coeff_loader_if.sv | 46 ++++
 rtl/hb_coeff_loader.sv | 171 +++++++++++++++++
 tb/tb_hb_coeff_loader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hb_coeff_loader_if.sv
// ---------------------------------------------------------------------------
// hb_coeff_loader_if
// Bundles the host-side staging/command signals and the halfband coefficient
// bus of hb_coeff_loader.
//   master : host / testbench side (drives cfg_*, load_start, load_mask)
//   slave  : hb_coeff_loader side (drives busy, load_done, cfg_wr_err,
//            hb_indicator, hb_param, config_sync)
// Optional: HB_LOADER_MASK_EN adds load_mask [NUM_HB-1:0].
// ---------------------------------------------------------------------------
interface hb_coeff_loader_if #(
  parameter int COEBITWIDTH = 16,
  parameter int NUM_HB      = 3,
  parameter int ADDRWIDTH   = 4
);
  logic                          cfg_we;
  logic [ADDRWIDTH-1:0]          cfg_addr;
  logic signed [COEBITWIDTH-1:0] cfg_wdata;
  logic                          load_start;
  logic                          busy;
  logic                          load_done;
  logic                          cfg_wr_err;
  logic [NUM_HB-1:0]             hb_indicator;
  logic signed [COEBITWIDTH-1:0] hb_param;
  logic                          config_sync;
`ifdef HB_LOADER_MASK_EN
  logic [NUM_HB-1:0]             load_mask;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, load_start, load_mask,
    input  busy, load_done, cfg_wr_err, hb_indicator, hb_param, config_sync
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, load_start, load_mask,
    output busy, load_done, cfg_wr_err, hb_indicator, hb_param, config_sync
  );
`else
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, load_start,
    input  busy, load_done, cfg_wr_err, hb_indicator, hb_param, config_sync
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, load_start,
    output busy, load_done, cfg_wr_err, hb_indicator, hb_param, config_sync
  );
`endif
endinterface

// File: rtl/hb_coeff_loader.sv
// ---------------------------------------------------------------------------
// hb_coeff_loader
// Coefficient transmitter for the DDC halfband decimation chain. Holds a
// staging bank of 4 symmetric-tap coefficients per halfband stage, shifts
// them serially into each stage (tap order 3,2,1,0) over the shared
// coefficient bus, then issues one config_sync pulse so every stage switches
// to the new set on the same clock.
// Ports:
//   clk        : clock
//   rst_param  : asynchronous, active-low reset (clears bank and outputs)
//   bus        : hb_coeff_loader_if.slave
//                  cfg_we/cfg_addr/cfg_wdata : staging-bank write
//                  load_start (+load_mask)   : transfer request
//                  busy, load_done, cfg_wr_err : status
//                  hb_indicator, hb_param, config_sync : coefficient bus
// Optional: define HB_LOADER_MASK_EN to add load_mask; stages whose mask bit
// is 0 are skipped and an all-zero mask ignores the start request.
// ---------------------------------------------------------------------------
module hb_coeff_loader #(
  parameter int COEBITWIDTH = 16,
  parameter int NUM_HB      = 3,
  parameter int ADDRWIDTH   = 4
) (
  input  logic               clk,
  input  logic               rst_param,
  hb_coeff_loader_if.slave   bus
);

  localparam int DEPTH = 4 * NUM_HB;
  localparam int SW    = (NUM_HB > 1) ? $clog2(NUM_HB) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, GAP, SYNC, DONE} state_e;

  state_e                        state_q, state_d;
  logic [SW-1:0]                 stage_q, stage_d;
  logic [1:0]                    tap_q, tap_d;
  logic [NUM_HB-1:0]             mask_q, mask_d;
  logic signed [COEBITWIDTH-1:0] bank_q [DEPTH];
  logic signed [COEBITWIDTH-1:0] bank_d [DEPTH];

  logic                          busy_q, busy_d;
  logic                          load_done_q, load_done_d;
  logic                          cfg_wr_err_q, cfg_wr_err_d;
  logic                          config_sync_q, config_sync_d;
  logic [NUM_HB-1:0]             hb_indicator_q, hb_indicator_d;
  logic signed [COEBITWIDTH-1:0] hb_param_q, hb_param_d;

  logic [NUM_HB-1:0]             start_mask;
  logic                          busy_now;
  logic                          wr_ok;
  logic [ADDRWIDTH-1:0]          rd_idx;

  // True if any enabled stage exists at index lo or above.
  function automatic logic has_stage_from(input logic [NUM_HB-1:0] m, input int lo);
    has_stage_from = 1'b0;
    for (int s = 0; s < NUM_HB; s++)
      if (m[s] && s >= lo) has_stage_from = 1'b1;
  endfunction

  // Lowest enabled stage at index lo or above (descending scan, lowest wins).
  function automatic logic [SW-1:0] first_stage_from(input logic [NUM_HB-1:0] m, input int lo);
    first_stage_from = '0;
    for (int s = NUM_HB - 1; s >= 0; s--)
      if (m[s] && s >= lo) first_stage_from = SW'(s);
  endfunction

`ifdef HB_LOADER_MASK_EN
  assign start_mask = bus.load_mask;
`else
  assign start_mask = '1;
`endif

  assign busy_now = (state_q == SHIFT) || (state_q == GAP) || (state_q == SYNC);
  assign wr_ok    = bus.cfg_we && !busy_now && (int'(bus.cfg_addr) < DEPTH);

  // Next-state, bank update and registered-output precomputation. Outputs are
  // derived from the *next* state so that they appear one edge after the
  // decision. The bus word is read from bank_d, which lets a write landing on
  // the same cycle as load_start be part of the transfer.
  always_comb begin
    state_d        = state_q;
    stage_d        = stage_q;
    tap_d          = tap_q;
    mask_d         = mask_q;
    bank_d         = bank_q;
    hb_indicator_d = '0;
    hb_param_d     = '0;
    rd_idx         = '0;

    for (int i = 0; i < DEPTH; i++)
      if (wr_ok && bus.cfg_addr == ADDRWIDTH'(i)) bank_d[i] = bus.cfg_wdata;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // DONE accepts a start so back-to-back transfers lose no cycle.
        if (bus.load_start && |start_mask) begin
          state_d = SHIFT;
          mask_d  = start_mask;
          stage_d = first_stage_from(start_mask, 0);
          tap_d   = 2'd3;
        end
      end
      SHIFT: begin
        if (tap_q != 2'd0) begin
          tap_d = tap_q - 2'd1;
        end else begin
          tap_d = 2'd3;
          if (has_stage_from(mask_q, int'(stage_q) + 1))
            stage_d = first_stage_from(mask_q, int'(stage_q) + 1);
          else
            state_d = GAP;
        end
      end
      GAP:     state_d = SYNC;
      SYNC:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (state_d == SHIFT) begin
      rd_idx = ADDRWIDTH'({stage_d, tap_d});
      for (int s = 0; s < NUM_HB; s++)
        hb_indicator_d[s] = (stage_d == SW'(s));
      for (int i = 0; i < DEPTH; i++)
        if (rd_idx == ADDRWIDTH'(i)) hb_param_d = bank_d[i];
    end

    busy_d        = (state_d == SHIFT) || (state_d == GAP) || (state_d == SYNC);
    config_sync_d = (state_d == SYNC);
    load_done_d   = (state_d == DONE);
    cfg_wr_err_d  = bus.cfg_we && !wr_ok;
  end

  // State, bank and output registers; reset clears everything so the
  // receivers (reset by the same signal) and this side agree on zeros.
  always_ff @(posedge clk or negedge rst_param) begin
    if (!rst_param) begin
      state_q        <= IDLE;
      stage_q        <= '0;
      tap_q          <= '0;
      mask_q         <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      busy_q         <= 1'b0;
      load_done_q    <= 1'b0;
      cfg_wr_err_q   <= 1'b0;
      config_sync_q  <= 1'b0;
      hb_indicator_q <= '0;
      hb_param_q     <= '0;
    end else begin
      state_q        <= state_d;
      stage_q        <= stage_d;
      tap_q          <= tap_d;
      mask_q         <= mask_d;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= bank_d[i];
      busy_q         <= busy_d;
      load_done_q    <= load_done_d;
      cfg_wr_err_q   <= cfg_wr_err_d;
      config_sync_q  <= config_sync_d;
      hb_indicator_q <= hb_indicator_d;
      hb_param_q     <= hb_param_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.load_done    = load_done_q;
  assign bus.cfg_wr_err   = cfg_wr_err_q;
  assign bus.config_sync  = config_sync_q;
  assign bus.hb_indicator = hb_indicator_q;
  assign bus.hb_param     = hb_param_q;

endmodule

// File: tb/tb_hb_coeff_loader.sv
// ---------------------------------------------------------------------------
// tb_hb_coeff_loader
// Scoreboard bench for hb_coeff_loader. The driver issues one stimulus cycle
// at a time and a transaction-level model predicts, with edge timestamps, the
// coefficient words, config_sync, load_done and cfg_wr_err pulses. A monitor
// samples the DUT on the falling edge, pops and compares, and also keeps a
// model of the halfband receivers' 4-deep shift chains.
// ---------------------------------------------------------------------------
module tb_hb_coeff_loader;

  localparam int COEBITWIDTH = 16;
  localparam int NUM_HB      = 3;
  localparam int ADDRWIDTH   = 4;
  localparam int DEPTH       = 4 * NUM_HB;

  typedef struct {
    int                     tag;
    logic [NUM_HB-1:0]      ind;
    logic [COEBITWIDTH-1:0] param;
  } word_ev_t;

  logic clk = 1'b0;
  logic rst_param = 1'b0;
  bit   monEn = 1'b0;
  int   edgeCount = 0;
  int   checkCount = 0;
  int   errorCount = 0;

  word_ev_t wordQ[$];
  int       syncQ[$];
  int       doneQ[$];
  int       errQ[$];

  logic [COEBITWIDTH-1:0] modelBank [DEPTH];
  int busyStart = 0;
  int busyEnd   = -1;

  logic [COEBITWIDTH-1:0] rxChain  [NUM_HB][4];
  logic [COEBITWIDTH-1:0] rxActive [NUM_HB][4];

  hb_coeff_loader_if #(.COEBITWIDTH(COEBITWIDTH), .NUM_HB(NUM_HB), .ADDRWIDTH(ADDRWIDTH)) bus ();

  hb_coeff_loader #(.COEBITWIDTH(COEBITWIDTH), .NUM_HB(NUM_HB), .ADDRWIDTH(ADDRWIDTH)) dut (
    .clk       (clk),
    .rst_param (rst_param),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  task automatic reportMissing(input string name, input int tag);
    checkCount++;
    errorCount++;
    $display("[TB] FAIL %s: got no event, expected one at edge %0d", name, tag);
  endtask

  task automatic checkPulse(ref int q[$], input string name, input logic actual, input int tag);
    while (q.size() > 0 && q[0] < tag) begin
      reportMissing(name, q[0]);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0] == tag) begin
      void'(q.pop_front());
      checkOutput(name, 32'(actual), 32'd1);
    end else begin
      checkOutput({name, " idle"}, 32'(actual), 32'd0);
    end
  endtask

  task automatic clearRx();
    for (int s = 0; s < NUM_HB; s++)
      for (int k = 0; k < 4; k++) begin
        rxChain[s][k]  = '0;
        rxActive[s][k] = '0;
      end
  endtask

  // Transaction-level prediction for one input cycle sampled at edge 'tag'.
  task automatic modelCycle(input int tag, input bit we, input int addr,
                            input logic [COEBITWIDTH-1:0] data, input bit start,
                            input logic [NUM_HB-1:0] mask);
    bit busy;
    int n;
    logic [NUM_HB-1:0] effMask;
    word_ev_t ev;
    busy = (tag >= busyStart) && (tag <= busyEnd);
    if (we) begin
      if (busy || addr >= DEPTH) errQ.push_back(tag + 1);
      else modelBank[addr] = data;
    end
`ifdef HB_LOADER_MASK_EN
    effMask = mask;
`else
    effMask = '1;
    if (mask == '0) effMask = '1;
`endif
    if (start && !busy) begin
      n = 0;
      for (int s = 0; s < NUM_HB; s++)
        if (effMask[s])
          for (int k = 3; k >= 0; k--) begin
            ev.tag   = tag + 1 + n;
            ev.ind   = NUM_HB'(1) << s;
            ev.param = modelBank[s * 4 + k];
            wordQ.push_back(ev);
            n++;
          end
      if (n > 0) begin
        syncQ.push_back(tag + n + 2);
        doneQ.push_back(tag + n + 3);
        busyStart = tag + 1;
        busyEnd   = tag + n + 2;
      end
    end
  endtask

  task automatic applyStimulus(input bit we, input int addr, input logic [COEBITWIDTH-1:0] data,
                               input bit start, input logic [NUM_HB-1:0] mask);
    @(negedge clk);
    bus.cfg_we     = we;
    bus.cfg_addr   = ADDRWIDTH'(addr);
    bus.cfg_wdata  = data;
    bus.load_start = start;
`ifdef HB_LOADER_MASK_EN
    bus.load_mask  = mask;
`endif
    modelCycle(edgeCount + 1, we, addr, data, start, mask);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, '0, 1'b0, '1);
  endtask

  task automatic waitIdle(input int bound);
    int cnt = 0;
    while ((wordQ.size() + syncQ.size() + doneQ.size() + errQ.size()) > 0 && cnt < bound) begin
      idleCycles(1);
      cnt++;
    end
    idleCycles(2);
    if ((wordQ.size() + syncQ.size() + doneQ.size() + errQ.size()) > 0)
      reportMissing("drain timeout", edgeCount);
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, " busy"},         32'(bus.busy),         32'd0);
    checkOutput({phase, " load_done"},    32'(bus.load_done),    32'd0);
    checkOutput({phase, " cfg_wr_err"},   32'(bus.cfg_wr_err),   32'd0);
    checkOutput({phase, " config_sync"},  32'(bus.config_sync),  32'd0);
    checkOutput({phase, " hb_indicator"}, 32'(bus.hb_indicator), 32'd0);
    checkOutput({phase, " hb_param"},     32'($unsigned(bus.hb_param)), 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_param      = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.load_start = 1'b0;
    wordQ.delete();
    syncQ.delete();
    doneQ.delete();
    errQ.delete();
    for (int i = 0; i < DEPTH; i++) modelBank[i] = '0;
    busyStart = 0;
    busyEnd   = -1;
    clearRx();
    #1;
    checkResetOutputs("mid-transfer reset");
    @(negedge clk);
    rst_param = 1'b1;
  endtask

  // Monitor: compares the outputs that the next rising edge will sample.
  always @(negedge clk) begin
    int tag;
    word_ev_t ev;
    logic expBusy;
    if (rst_param && monEn) begin
      tag = edgeCount + 1;
      while (wordQ.size() > 0 && wordQ[0].tag < tag) begin
        reportMissing("hb word", wordQ[0].tag);
        void'(wordQ.pop_front());
      end
      if (wordQ.size() > 0 && wordQ[0].tag == tag) begin
        ev = wordQ.pop_front();
        checkOutput("hb_indicator", 32'(bus.hb_indicator), 32'(ev.ind));
        checkOutput("hb_param", 32'($unsigned(bus.hb_param)), 32'(ev.param));
      end else begin
        checkOutput("hb_indicator idle", 32'(bus.hb_indicator), 32'd0);
        checkOutput("hb_param idle", 32'($unsigned(bus.hb_param)), 32'd0);
      end
      checkPulse(syncQ, "config_sync", bus.config_sync, tag);
      checkPulse(doneQ, "load_done", bus.load_done, tag);
      checkPulse(errQ, "cfg_wr_err", bus.cfg_wr_err, tag);
      expBusy = (tag >= busyStart) && (tag <= busyEnd);
      checkOutput("busy", 32'(bus.busy), 32'(expBusy));

      for (int s = 0; s < NUM_HB; s++)
        if (bus.hb_indicator[s]) begin
          for (int k = 3; k > 0; k--) rxChain[s][k] = rxChain[s][k-1];
          rxChain[s][0] = bus.hb_param;
        end
      if (bus.config_sync)
        for (int s = 0; s < NUM_HB; s++)
          for (int k = 0; k < 4; k++) rxActive[s][k] = rxChain[s][k];
    end
  end

  initial begin
    int r;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_wdata  = '0;
    bus.load_start = 1'b0;
`ifdef HB_LOADER_MASK_EN
    bus.load_mask  = '1;
`endif
    for (int i = 0; i < DEPTH; i++) modelBank[i] = '0;
    clearRx();

    // Reset values while rst_param is held low.
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_param = 1'b1;
    monEn     = 1'b1;
    idleCycles(2);

    // Empty bank: twelve zero words, sync at E+14, done at E+15.
    applyStimulus(1'b0, 0, '0, 1'b1, '1);
    waitIdle(40);

    // Full load with a recognisable pattern.
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, k, COEBITWIDTH'(16'h1000 + k), 1'b0, '1);
    applyStimulus(1'b0, 0, '0, 1'b1, '1);
    waitIdle(40);
    for (int s = 0; s < NUM_HB; s++) begin
      checkOutput($sformatf("rx stage%0d coeff1", s), 32'(rxActive[s][0]), 32'(16'h1000 + 4 * s));
      checkOutput($sformatf("rx stage%0d coeff7", s), 32'(rxActive[s][3]), 32'(16'h1003 + 4 * s));
    end

    // Start at E, second start at E+5, write at E+6 while busy.
    applyStimulus(1'b0, 0, '0, 1'b1, '1);
    idleCycles(4);
    applyStimulus(1'b0, 0, '0, 1'b1, '1);
    applyStimulus(1'b1, 0, 16'hDEAD, 1'b0, '1);
    waitIdle(40);
    checkOutput("rx after rejected write", 32'(rxActive[0][0]), 32'h1000);

    // Out-of-range write, then same-cycle write and start.
    applyStimulus(1'b1, 12, 16'h5555, 1'b0, '1);
    idleCycles(2);
    applyStimulus(1'b1, 3, 16'h7FFF, 1'b1, '1);
    waitIdle(40);
    checkOutput("rx same-cycle write", 32'(rxActive[0][3]), 32'h7FFF);

    // Reset in the middle of a transfer, then reload from a cleared bank.
    applyStimulus(1'b0, 0, '0, 1'b1, '1);
    idleCycles(5);
    pulseReset();
    idleCycles(20);
    checkOutput("rx not committed by aborted load", 32'(rxActive[1][1]), 32'h0);
    applyStimulus(1'b0, 0, '0, 1'b1, '1);
    waitIdle(40);
    checkOutput("rx zeros after reload", 32'(rxActive[2][3]), 32'h0);

`ifdef HB_LOADER_MASK_EN
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, k, COEBITWIDTH'(16'h2000 + k), 1'b0, '1);
    applyStimulus(1'b0, 0, '0, 1'b1, 3'b101);
    waitIdle(40);
    checkOutput("mask rx stage2 coeff7", 32'(rxActive[2][3]), 32'h200B);
    applyStimulus(1'b0, 0, '0, 1'b1, 3'b000);
    idleCycles(1);
    checkOutput("zero mask busy", 32'(bus.busy), 32'd0);
    idleCycles(3);
`endif

    // Randomised traffic: writes anywhere, starts at any time.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      applyStimulus(r < 5, $urandom_range(0, 15), COEBITWIDTH'($urandom),
                    (r == 4) || (r >= 8), NUM_HB'($urandom_range(0, 7)));
    end
    waitIdle(60);

    checkOutput("queues drained", 32'(wordQ.size() + syncQ.size() + doneQ.size() + errQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
